mul_datapath: RTL

MUL_DATAPATH -- requirements
Module: mul_datapath

---
 rtl/mul_datapath.sv | 118 +++++++++++
 1 files changed

// File: rtl/mul_datapath.sv
// mul_datapath: register datapath for a shift-free add-and-decrement multiplier.
// R1 is the loop counter (smaller operand), R2/R4 hold the addend and R3
// accumulates the product. All sequencing comes from an external control unit
// through the load/clear/decrement strobes; the datapath only reports OR_R1 and
// CMP_L_R1 back combinationally so the control unit can branch in-cycle.
// Optional build macro: MUL_DATAPATH_ITER_CNT_EN adds the Iter output, a
// saturating count of cycles in which R1 actually decremented.
module mul_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               L_R1,
  input  logic               L_R2,
  input  logic               L_R3,
  input  logic               L_R4,
  input  logic               R_R3,
  input  logic               Dec_R1,
  input  logic               Sel_R1,
  input  logic               Sel_R2,
  input  logic               S_R,
  input  logic               R_R,
  output logic               OR_R1,
  output logic               CMP_L_R1,
  output logic [2*WIDTH-1:0] P,
`ifdef MUL_DATAPATH_ITER_CNT_EN
  output logic [WIDTH-1:0]   Iter,
`endif
  output logic               Ready
);

  logic [WIDTH-1:0]   r1;
  logic [WIDTH-1:0]   r2;
  logic [2*WIDTH-1:0] r3;
  logic [2*WIDTH-1:0] r4;
  logic               ready;

  // R1 actually moves down only when decrementing without a load and not already at zero
  logic               r1_dec_ok;
  assign r1_dec_ok = Dec_R1 && !L_R1 && (r1 != '0);

  // R1: load (from R2 or A) has priority over the non-wrapping decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      r1 <= '0;
    end else if (L_R1) begin
      r1 <= Sel_R1 ? r2 : A;
    end else if (r1_dec_ok) begin
      r1 <= r1 - 1'b1;
    end
  end

  // R2: loads from R1 or B; pre-edge R1 is used so a simultaneous R1 load swaps
  always_ff @(posedge clk) begin
    if (rst) begin
      r2 <= '0;
    end else if (L_R2) begin
      r2 <= Sel_R2 ? r1 : B;
    end
  end

  // R4: zero-extended copy of R2 used as the loop addend
  always_ff @(posedge clk) begin
    if (rst) begin
      r4 <= '0;
    end else if (L_R4) begin
      r4 <= {{WIDTH{1'b0}}, r2};
    end
  end

  // R3: accumulator; clear wins over accumulate, sum wraps at 2*WIDTH bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r3 <= '0;
    end else if (R_R3) begin
      r3 <= '0;
    end else if (L_R3) begin
      r3 <= r3 + r4;
    end
  end

  // Ready flag: clear has priority over set
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
    end else if (R_R) begin
      ready <= 1'b0;
    end else if (S_R) begin
      ready <= 1'b1;
    end
  end

`ifdef MUL_DATAPATH_ITER_CNT_EN
  logic [WIDTH-1:0] iter_cnt;

  // Iteration counter: clears with the accumulator, saturates at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (R_R3) begin
      iter_cnt <= '0;
    end else if (r1_dec_ok && (iter_cnt != {WIDTH{1'b1}})) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end

  assign Iter = iter_cnt;
`endif

  // Status back to the control unit is combinational so it can branch in the same cycle
  assign OR_R1    = |r1;
  assign CMP_L_R1 = (r1 < r2);
  assign P        = r3;
  assign Ready    = ready;

endmodule
